// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and helpers for the 4-channel round-robin stage
// Purpose : channel count, channel index type and pointer-advance helper
//           used by rr_pick_4 and rr_arb_4_stage.
// Ports   : none (package).
package rr_arb_pkg;

  localparam int N_CH = 4;

  typedef logic [1:0] ch_idx_t;

  // Pointer moves to the channel just after the winner; 2-bit wrap gives mod 4.
  function automatic ch_idx_t next_ptr(input ch_idx_t g);
    return g + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick_4.sv
// rtl/rr_pick_4.sv - combinational round-robin pick among four requests
// Purpose : finds the first asserted request searching ptr, ptr+1, ... mod 4.
// Ports   : in_valid [3:0] request vector
//           ptr            highest-priority channel
//           any            at least one request asserted
//           g              winning channel (equals ptr when any=0)
module rr_pick_4
  import rr_arb_pkg::*;
(
  input  logic [3:0] in_valid,
  input  ch_idx_t    ptr,
  output logic       any,
  output ch_idx_t    g
);

  ch_idx_t idx;
  logic    found;

  always_comb begin
    any   = |in_valid;
    g     = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      idx = ptr + ch_idx_t'(k);
      if (!found && in_valid[idx]) begin
        g     = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arb_4_stage.sv
// rtl/rr_arb_4_stage.sv - round-robin 4:1 request stage with registered output
// Purpose : arbitrates four valid/ready requesters round-robin, registers the
//           winning word and its channel index behind a valid/ready output.
// Ports   : clk, rst (async, active-high)
//           in_valid [3:0], in_data [4*W-1:0] (ch k at [k*W +: W]), in_ready [3:0]
//           out_valid, out_ready, out_data [W-1:0], out_sel [1:0]
// Config  : RR_ARB_4_SKID_EN adds a 1-entry skid buffer so in_ready depends only
//           on registered state (no combinational out_ready -> in_ready path).
module rr_arb_4_stage
  import rr_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     in_valid,
  input  logic [4*W-1:0] in_data,
  output logic [3:0]     in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_sel
);

  ch_idx_t        ptr;
  ch_idx_t        g;
  logic           any;
  logic           load;
  logic [W-1:0]   g_data;

  rr_pick_4 u_pick (
    .in_valid (in_valid),
    .ptr      (ptr),
    .any      (any),
    .g        (g)
  );

  assign g_data = in_data[int'(g)*W +: W];

`ifdef RR_ARB_4_SKID_EN
  logic           skid_valid;
  logic [W-1:0]   skid_data;
  ch_idx_t        skid_sel;
  logic           out_free;

  // Accept whenever the skid slot is empty; the output register state only
  // decides where the word lands, never whether it is accepted.
  assign out_free = !out_valid || out_ready;
  assign load     = !skid_valid && any;
`else
  assign load     = (!out_valid || out_ready) && any;
`endif

  // Held at zero during reset so no upstream sees a grant that will be dropped.
  assign in_ready = (load && !rst) ? (4'b0001 << g) : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
`ifdef RR_ARB_4_SKID_EN
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_sel   <= '0;
`endif
    end else begin
`ifdef RR_ARB_4_SKID_EN
      if (skid_valid) begin
        // Skid drains first; out_valid is already 1 while skid is occupied.
        if (out_free) begin
          out_data   <= skid_data;
          out_sel    <= skid_sel;
          skid_valid <= 1'b0;
        end
      end else if (load) begin
        ptr <= next_ptr(g);
        if (out_free) begin
          out_data  <= g_data;
          out_sel   <= g;
          out_valid <= 1'b1;
        end else begin
          skid_data  <= g_data;
          skid_sel   <= g;
          skid_valid <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
`else
      if (load) begin
        ptr       <= next_ptr(g);
        out_data  <= g_data;
        out_sel   <= g;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rr_arb_4_stage.sv
// tb/tb_rr_arb_4_stage.sv - self-checking bench for rr_arb_4_stage
module tb_rr_arb_4_stage;

  localparam int W = 4;
`ifdef RR_ARB_4_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;

  int total;
  int bad;

  // Reference model: words accepted but not yet consumed downstream, in order.
  logic [W-1:0] q_data[$];
  logic [1:0]   q_sel[$];
  int           m_ptr;
  int           wait_cnt[4];
  logic [3:0]   obs_ir;

  rr_arb_4_stage #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    q_data.delete();
    q_sel.delete();
    m_ptr = 0;
    for (int c = 0; c < 4; c++) wait_cnt[c] = 0;
  endtask

  // One clock cycle: drive at negedge, check just after, commit model at posedge.
  task automatic cyc(input logic [3:0] v, input logic r, input logic [4*W-1:0] d);
    bit         can;
    int         g;
    int         c;
    int         obs_g;
    logic [3:0] exp_ir;
    @(negedge clk);
    in_valid  = v;
    out_ready = r;
    in_data   = d;
    #1;
    total++;
    if (out_valid !== (q_data.size() > 0)) begin
      bad++;
      $display("FAIL out_valid: got %b want %b", out_valid, q_data.size() > 0);
    end
    if (q_data.size() > 0) begin
      total++;
      if (out_data !== q_data[0]) begin
        bad++;
        $display("FAIL out_data: got %h want %h", out_data, q_data[0]);
      end
      total++;
      if (out_sel !== q_sel[0]) begin
        bad++;
        $display("FAIL out_sel: got %0d want %0d", out_sel, q_sel[0]);
      end
    end
    can = SKID ? (q_data.size() < 2) : (q_data.size() == 0 || r);
    g = -1;
    if (can) begin
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (g < 0 && v[c]) g = c;
      end
    end
    exp_ir = (g >= 0) ? 4'(1 << g) : 4'b0000;
    obs_ir = in_ready;
    total++;
    if (in_ready !== exp_ir) begin
      bad++;
      $display("FAIL in_ready: got %b want %b", in_ready, exp_ir);
    end
    total++;
    if ($countones(in_ready) > 1) begin
      bad++;
      $display("FAIL in_ready_onehot: got %b want at most one bit", in_ready);
    end
    // Fairness measured from the DUT's own grants.
    obs_g = -1;
    for (int k = 0; k < 4; k++) if (in_ready[k] && v[k]) obs_g = k;
    for (int k = 0; k < 4; k++) begin
      if (!v[k] || k == obs_g) wait_cnt[k] = 0;
      else if (obs_g >= 0) wait_cnt[k]++;
    end
    total++;
    if (wait_cnt[0] > 3 || wait_cnt[1] > 3 || wait_cnt[2] > 3 || wait_cnt[3] > 3) begin
      bad++;
      $display("FAIL fairness: got waits %0d %0d %0d %0d want <= 3",
               wait_cnt[0], wait_cnt[1], wait_cnt[2], wait_cnt[3]);
    end
    @(posedge clk);
    if (q_data.size() > 0 && r) begin
      void'(q_data.pop_front());
      void'(q_sel.pop_front());
    end
    if (g >= 0) begin
      q_data.push_back(d[g*W +: W]);
      q_sel.push_back(2'(g));
      m_ptr = (g + 1) % 4;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 4'b0000;
    #2;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if (out_sel !== 2'd0) begin bad++; $display("FAIL reset_out_sel: got %0d want 0", out_sel); end
    total++;
    if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    total++;
    if (in_ready !== 4'b0000) begin bad++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_all_valid();
    logic [4*W-1:0] d;
    d = {4'd4, 4'd3, 4'd2, 4'd1};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, 1'b1, d);
      #1;
      total++;
      if (out_valid !== 1'b1 || out_sel !== 2'(i % 4) || out_data !== 4'(i % 4 + 1)) begin
        bad++;
        $display("FAIL all_valid[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%0d",
                 i, out_valid, out_sel, out_data, i % 4, i % 4 + 1);
      end
    end
  endtask

  task automatic test_single_and_wrap();
    logic [4*W-1:0] d;
    apply_reset();
    d = {4'h0, 4'hA, 4'h0, 4'h0};
    cyc(4'b0100, 1'b1, d);
    total++;
    if (obs_ir !== 4'b0100) begin bad++; $display("FAIL single_in_ready: got %b want 0100", obs_ir); end
    #1;
    total++;
    if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 4'hA) begin
      bad++;
      $display("FAIL single_out: got v=%b sel=%0d data=%h want v=1 sel=2 data=a", out_valid, out_sel, out_data);
    end
    d = {4'h7, 4'h0, 4'h0, 4'h5};
    cyc(4'b1001, 1'b1, d);
    #1;
    total++;
    if (out_sel !== 2'd3 || out_data !== 4'h7) begin
      bad++;
      $display("FAIL wrap_first: got sel=%0d data=%h want sel=3 data=7", out_sel, out_data);
    end
    cyc(4'b1001, 1'b1, d);
    #1;
    total++;
    if (out_sel !== 2'd0 || out_data !== 4'h5) begin
      bad++;
      $display("FAIL wrap_second: got sel=%0d data=%h want sel=0 data=5", out_sel, out_data);
    end
  endtask

  task automatic test_stall();
    logic [4*W-1:0] d;
    int acc;
    apply_reset();
    d = {4'hD, 4'hC, 4'hB, 4'hE};
    cyc(4'b1111, 1'b1, d);
    cyc(4'b1111, 1'b1, d);
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(4'b1111, 1'b0, d);
      if (obs_ir != 4'b0000) acc++;
    end
    total++;
    if (acc !== (SKID ? 1 : 0)) begin
      bad++;
      $display("FAIL stall_accepts: got %0d want %0d", acc, SKID ? 1 : 0);
    end
    for (int i = 0; i < 6; i++) cyc(4'b1111, 1'b1, d);
    for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b1, d);
  endtask

  task automatic test_reset_mid();
    logic [4*W-1:0] d;
    apply_reset();
    d = {4'h4, 4'h3, 4'h2, 4'h1};
    cyc(4'b1111, 1'b1, d);
    cyc(4'b1111, 1'b1, d);
    #3;
    in_valid = 4'b0000;
    rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
    total++;
    if (out_sel !== 2'd0 || out_data !== '0) begin
      bad++;
      $display("FAIL mid_reset_regs: got sel=%0d data=%h want 0 0", out_sel, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc(4'b1111, 1'b1, d);
    #1;
    total++;
    if (out_sel !== 2'd0 || out_data !== 4'h1) begin
      bad++;
      $display("FAIL mid_reset_ptr: got sel=%0d data=%h want sel=0 data=1", out_sel, out_data);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 10000; i++) begin
      cyc(4'($urandom), ($urandom_range(0, 9) < 7), 16'($urandom));
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 4'b0000;
    in_data   = '0;
    out_ready = 1'b0;
    obs_ir    = 4'b0000;
    model_reset();
    test_reset();
    test_all_valid();
    test_single_and_wrap();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
